// File: rtl/vote_pkg.sv
// Shared definitions for the vote frame assembler: voter count, legal id range,
// FSM state encoding and a helper that maps a voter id to its frame bit.
package vote_pkg;

  localparam int NUM_VOTERS  = 5;
  localparam int VOTE_ID_MIN = 1;
  localparam int VOTE_ID_MAX = 5;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    HOLD    = 2'd2
  } vote_state_t;

  // One-hot frame mask for a voter id; all-zero for an illegal id.
  function automatic logic [NUM_VOTERS:1] vote_mask(input logic [2:0] id);
    logic [NUM_VOTERS:1] m;
    m = '0;
    for (int i = VOTE_ID_MIN; i <= VOTE_ID_MAX; i++) begin
      if (int'(id) == i) m[i] = 1'b1;
    end
    return m;
  endfunction

endpackage

// File: rtl/vote_timer.sv
// Frame timer: restarted at the first vote of a frame, advances while the frame
// is collecting, and flags expiry on the edge that must close the frame.
module vote_timer #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic clear,
  input  logic enable,
  output logic expire
);

  localparam int unsigned CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

  logic [CW-1:0] count_q, count_d;

  // The first vote's edge loads count 0; the edge seeing LAST closes the frame.
  assign expire = enable && (count_q == LAST);

  always_comb begin
    count_d = count_q;
    if (start || clear) begin
      count_d = '0;
    end else if (enable && !expire) begin
      count_d = count_q + CW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/vote_frame_assembler.sv
// Assembles five serial single-bit votes into a registered 5-bit frame for the
// downstream 3-of-5 majority stage, closing incomplete frames on timeout.
module vote_frame_assembler
  import vote_pkg::*;
#(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  vote_valid,
  output logic                  vote_ready,
  input  logic [2:0]            vote_id,
  input  logic                  vote_bit,
  output logic [NUM_VOTERS:1]   x,
  output logic [NUM_VOTERS:1]   present,
  output logic                  x_valid,
  input  logic                  x_ready,
  output logic                  timed_out,
  output logic                  err,
  output vote_state_t           state_dbg
);

  // Handshakes: a transfer happens on a rising edge where valid && ready are
  // both high; valid never waits on ready, and a held frame stays unchanged
  // until it is taken.

  vote_state_t         state_q, state_d;
  logic [NUM_VOTERS:1] x_q, x_d;
  logic [NUM_VOTERS:1] present_q, present_d;
  logic                timed_out_q, timed_out_d;
  logic                err_q, err_d;

  logic [NUM_VOTERS:1] vote_sel;
  logic                vote_acc;
  logic                id_legal;
  logic                dup;
  logic                take_vote;
  logic                handshake;
  logic                frame_full;
  logic                timer_start;
  logic                timer_clear;
  logic                timer_en;
  logic                timer_expire;

  always_comb begin
    vote_sel    = vote_mask(vote_id);
    vote_acc    = vote_valid && vote_ready;
    id_legal    = |vote_sel;
    dup         = |(vote_sel & present_q);
    take_vote   = vote_acc && id_legal && !dup;
    handshake   = (state_q == HOLD) && x_ready;
    timer_start = (state_q == IDLE) && take_vote;
    timer_clear = handshake;
    timer_en    = (state_q == COLLECT);
  end

  vote_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_timer (
    .clk    (clk),
    .rst    (rst),
    .start  (timer_start),
    .clear  (timer_clear),
    .enable (timer_en),
    .expire (timer_expire)
  );

  // Vote capture: illegal and duplicate votes are consumed but only raise err.
  always_comb begin
    x_d         = x_q;
    present_d   = present_q;
    timed_out_d = timed_out_q;
    err_d       = vote_acc && !take_vote;
    if (handshake) begin
      x_d         = '0;
      present_d   = '0;
      timed_out_d = 1'b0;
    end else if (take_vote) begin
      present_d = present_q | vote_sel;
      x_d       = (x_q & ~vote_sel) | (vote_bit ? vote_sel : '0);
    end
    frame_full = &present_d;
    // A vote completing the frame on the expiry edge wins over the timeout.
    if ((state_q == COLLECT) && timer_expire && !frame_full) begin
      timed_out_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x_q         <= '0;
      present_q   <= '0;
      timed_out_q <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      x_q         <= x_d;
      present_q   <= present_d;
      timed_out_q <= timed_out_d;
      err_q       <= err_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (take_vote) state_d = COLLECT;
      COLLECT: if (frame_full || timer_expire) state_d = HOLD;
      HOLD:    if (x_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    vote_ready = (state_q != HOLD);
    x_valid    = (state_q == HOLD);
    x          = x_q;
    present    = present_q;
    timed_out  = timed_out_q;
    err        = err_q;
    state_dbg  = state_q;
  end

endmodule

// File: tb/tb_vote_frame_assembler.sv
// Bench for vote_frame_assembler: directed scenarios plus random traffic, with
// a transaction-level reference model feeding a frame scoreboard and err queue.
module tb_vote_frame_assembler;
  import vote_pkg::*;

  localparam int TO = 16;

  typedef struct packed {
    logic [4:0] x;
    logic [4:0] p;
    logic       to;
    int         rise;
  } frame_t;

  logic        clk;
  logic        rst;
  logic        vote_valid;
  logic        vote_ready;
  logic [2:0]  vote_id;
  logic        vote_bit;
  logic [5:1]  x;
  logic [5:1]  present;
  logic        x_valid;
  logic        x_ready;
  logic        timed_out;
  logic        err;
  vote_state_t state_dbg;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  frame_t frame_q[$];
  int     err_exp_q[$];

  // Reference model: what the frame currently holds and whether it is closed.
  bit         m_open;
  bit         m_hold;
  int         m_first;
  logic [5:1] m_x;
  logic [5:1] m_p;
  bit         xv_prev;

  vote_frame_assembler #(
    .TIMEOUT (TO)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .vote_valid (vote_valid),
    .vote_ready (vote_ready),
    .vote_id    (vote_id),
    .vote_bit   (vote_bit),
    .x          (x),
    .present    (present),
    .x_valid    (x_valid),
    .x_ready    (x_ready),
    .timed_out  (timed_out),
    .err        (err),
    .state_dbg  (state_dbg)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    failures++;
    $display("FAIL %s: cycle %0d", name, cyc);
  endtask

  task automatic model_clear();
    m_open  = 1'b0;
    m_hold  = 1'b0;
    m_first = 0;
    m_x     = '0;
    m_p     = '0;
  endtask

  // Applies one rising edge's worth of inputs to the reference model.
  task automatic model_edge(input bit v, input logic [2:0] id, input bit b, input bit xr);
    int idx;
    frame_t f;
    idx = int'(id);
    if (m_hold) begin
      if (xr) model_clear();
    end else begin
      if (v) begin
        if (idx < 1 || idx > 5) begin
          err_exp_q.push_back(cyc);
        end else if (m_open && m_p[idx]) begin
          err_exp_q.push_back(cyc);
        end else begin
          if (!m_open) begin
            m_open  = 1'b1;
            m_first = cyc;
          end
          m_p[idx] = 1'b1;
          m_x[idx] = b;
        end
      end
      if (m_open && (m_p == 5'b11111 || (cyc - m_first) >= TO)) begin
        m_hold = 1'b1;
        f.x    = m_x;
        f.p    = m_p;
        f.to   = (m_p != 5'b11111);
        f.rise = cyc;
        frame_q.push_back(f);
      end
    end
  endtask

  task automatic step(input bit v, input logic [2:0] id, input bit b, input bit xr);
    vote_valid = v;
    vote_id    = id;
    vote_bit   = b;
    x_ready    = xr;
    @(posedge clk);
    cyc++;
    if (!rst) model_edge(v, id, b, xr);
    #1;
  endtask

  task automatic idle(input int n, input bit xr);
    for (int i = 0; i < n; i++) step(1'b0, 3'd0, 1'b0, xr);
  endtask

  task automatic check_reset_outputs();
    chk("rst_vote_ready", int'(vote_ready), 1);
    chk("rst_x", int'(x), 0);
    chk("rst_present", int'(present), 0);
    chk("rst_x_valid", int'(x_valid), 0);
    chk("rst_timed_out", int'(timed_out), 0);
    chk("rst_err", int'(err), 0);
  endtask

  // Monitor: checks every presented frame and err pulse against the queues.
  always @(negedge clk) begin
    if (rst) begin
      xv_prev = 1'b0;
    end else begin
      chk("vote_ready", int'(vote_ready), int'(!m_hold));
      if (x_valid) begin
        if (frame_q.size() == 0) begin
          fail_now("unexpected_frame");
        end else begin
          if (!xv_prev) chk("x_valid_rise_cycle", cyc, frame_q[0].rise);
          chk("frame_x", int'(x), int'(frame_q[0].x));
          chk("frame_present", int'(present), int'(frame_q[0].p));
          chk("frame_timed_out", int'(timed_out), int'(frame_q[0].to));
          if (x_ready) void'(frame_q.pop_front());
        end
      end else if (frame_q.size() != 0 && cyc >= frame_q[0].rise) begin
        fail_now("x_valid_missing");
        void'(frame_q.pop_front());
      end
      if (err) begin
        if (err_exp_q.size() == 0) fail_now("unexpected_err");
        else chk("err_cycle", cyc, err_exp_q.pop_front());
      end else if (err_exp_q.size() != 0 && err_exp_q[0] <= cyc) begin
        fail_now("err_missing");
        void'(err_exp_q.pop_front());
      end
      xv_prev = x_valid;
    end
  end

  initial begin
    rst        = 1'b1;
    vote_valid = 1'b0;
    vote_id    = 3'd0;
    vote_bit   = 1'b0;
    x_ready    = 1'b0;
    model_clear();
    #12;
    check_reset_outputs();
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Full frame, x = 5'b01101.
    step(1, 3'd1, 1, 0);
    step(1, 3'd2, 0, 0);
    step(1, 3'd3, 1, 0);
    step(1, 3'd4, 1, 0);
    step(1, 3'd5, 0, 0);
    chk("full_x_direct", int'(x), 5'b01101);
    idle(2, 1);

    // Timeout with two voters.
    step(1, 3'd2, 1, 0);
    step(1, 3'd4, 1, 0);
    idle(TO + 1, 0);
    chk("timeout_flag_direct", int'(timed_out), 1);
    idle(1, 1);

    // Illegal ids while idle: consumed, err, no frame.
    step(1, 3'd0, 1, 0);
    step(1, 3'd6, 0, 0);
    step(1, 3'd7, 1, 0);
    idle(2, 0);

    // Duplicate and illegal votes during collection.
    step(1, 3'd3, 1, 0);
    step(1, 3'd3, 0, 0);
    step(1, 3'd7, 1, 0);
    idle(TO, 0);
    idle(1, 1);

    // Backpressure: frame held for ten cycles.
    step(1, 3'd5, 1, 0);
    step(1, 3'd1, 0, 0);
    step(1, 3'd4, 1, 0);
    step(1, 3'd2, 1, 0);
    step(1, 3'd3, 0, 0);
    idle(10, 0);
    idle(2, 1);

    // Fifth distinct vote on the expiry edge counts as complete.
    step(1, 3'd1, 1, 0);
    step(1, 3'd2, 0, 0);
    step(1, 3'd3, 1, 0);
    step(1, 3'd4, 0, 0);
    idle(TO - 4, 0);
    step(1, 3'd5, 1, 0);
    chk("boundary_timed_out_direct", int'(timed_out), 0);
    idle(1, 1);

    // Asynchronous reset with three votes held.
    step(1, 3'd1, 1, 0);
    step(1, 3'd2, 1, 0);
    step(1, 3'd3, 1, 0);
    #2;
    rst = 1'b1;
    #1;
    check_reset_outputs();
    model_clear();
    frame_q.delete();
    err_exp_q.delete();
    step(0, 3'd0, 0, 0);
    #2;
    rst = 1'b0;
    step(1, 3'd4, 0, 0);
    step(1, 3'd5, 1, 0);
    step(1, 3'd1, 0, 0);
    step(1, 3'd2, 1, 0);
    step(1, 3'd3, 1, 0);
    idle(2, 1);

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      step(bit'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
           bit'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0));
    end
    idle(TO + 4, 1);

    chk("frames_left", frame_q.size(), 0);
    chk("errs_left", err_exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
